// File: rtl/irin_pkg.sv
// Shared definitions for the NEC infrared receiver.
//   - state_t  : decoder FSM states
//   - NOM_*    : nominal NEC pulse widths in microseconds
//   - win_lo / win_hi : acceptance window bounds for a nominal width,
//     evaluated at elaboration time from the tolerance percentage
package irin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_MARK,
        ST_LEAD_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_STOP_MARK,
        ST_REP_STOP
    } state_t;

    localparam int DUR_W          = 16;
    localparam int NOM_LEAD_MARK  = 9000;
    localparam int NOM_LEAD_SPACE = 4500;
    localparam int NOM_REP_SPACE  = 2250;
    localparam int NOM_BIT_MARK   = 560;
    localparam int NOM_ONE_SPACE  = 1690;

    function automatic int win_lo(input int nom, input int tol_pct);
        return nom * (100 - tol_pct) / 100;
    endfunction

    function automatic int win_hi(input int nom, input int tol_pct);
        return nom * (100 + tol_pct) / 100;
    endfunction

endpackage

// File: rtl/irin_pulse_timer.sv
// Front end of the NEC receiver: input synchroniser, 1 us tick, glitch
// filter and mark/space duration counter.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   ir         : raw demodulated IR input (idle high), asynchronous
//   tick       : one-clk enable every microsecond
//   level      : filtered IR level
//   fall, rise : one-clk strobes on filtered falling / rising edges
//   dur        : length in us of the segment that ended at the last edge
//   sat        : running segment counter has saturated at 65535
module irin_pulse_timer
    import irin_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ir,
    output logic             tick,
    output logic             level,
    output logic             fall,
    output logic             rise,
    output logic [DUR_W-1:0] dur,
    output logic             sat
);

    localparam int TICK_DIV = CLK_FREQ_HZ / 1000000;
    localparam int TW       = $clog2(TICK_DIV);

    logic [TW-1:0]    tick_cnt;
    logic [1:0]       sync;
    logic [1:0]       flt_cnt;
    logic [DUR_W-1:0] run_cnt;
    logic             flip;

    assign tick = (tick_cnt == '0);
    assign sat  = (run_cnt == {DUR_W{1'b1}});
    // The filtered level follows only on the 4th consecutive sample that
    // disagrees with it, so anything shorter than 4 us never reaches the FSM.
    assign flip = tick && (sync[1] != level) && (flt_cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            sync     <= 2'b11;
            level    <= 1'b1;
            flt_cnt  <= '0;
            run_cnt  <= '0;
            dur      <= '0;
            fall     <= 1'b0;
            rise     <= 1'b0;
        end else begin
            fall <= 1'b0;
            rise <= 1'b0;
            sync <= {sync[0], ir};
            tick_cnt <= tick ? TW'(TICK_DIV - 1) : tick_cnt - TW'(1);
            if (tick) begin
                if (sync[1] != level && !flip) begin
                    flt_cnt <= flt_cnt + 2'd1;
                end else begin
                    flt_cnt <= '0;
                end
                if (flip) begin
                    level   <= sync[1];
                    fall    <= ~sync[1];
                    rise    <= sync[1];
                    dur     <= run_cnt;
                    run_cnt <= '0;
                end else if (!sat) begin
                    run_cnt <= run_cnt + DUR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/irin_nec.sv
// NEC infrared remote decoder.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   ir         : raw demodulated IR input, idle high, burst = low
//   code       : command byte of the last accepted frame
//   address    : address of the last accepted frame, {byte1, byte0}
//   valid      : one-clk pulse when a frame is accepted
//   rpt        : one-clk pulse for an accepted repeat code ("repeat" is a
//                language keyword, hence the short name)
//   error      : one-clk pulse when a started frame is aborted
//   pressed    : high while a key is considered held
// Handshake: valid/rpt/error are single-cycle strobes with no back-pressure;
// code/address are stable from the valid strobe until the next accepted frame.
// The FSM state is held in the signal `state` for observation.
module irin_nec
    import irin_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int TOL_PCT     = 25,
    parameter int CHECK_INV   = 1,
    parameter int HOLD_US     = 110000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir,
    output logic [7:0]  code,
    output logic [15:0] address,
    output logic        valid,
    output logic        rpt,
    output logic        error,
    output logic        pressed
);

    localparam int HOLD_W = $clog2(HOLD_US + 1);

    localparam logic [DUR_W-1:0] LEAD_LO = DUR_W'(win_lo(NOM_LEAD_MARK,  TOL_PCT));
    localparam logic [DUR_W-1:0] LEAD_HI = DUR_W'(win_hi(NOM_LEAD_MARK,  TOL_PCT));
    localparam logic [DUR_W-1:0] LSP_LO  = DUR_W'(win_lo(NOM_LEAD_SPACE, TOL_PCT));
    localparam logic [DUR_W-1:0] LSP_HI  = DUR_W'(win_hi(NOM_LEAD_SPACE, TOL_PCT));
    localparam logic [DUR_W-1:0] RSP_LO  = DUR_W'(win_lo(NOM_REP_SPACE,  TOL_PCT));
    localparam logic [DUR_W-1:0] RSP_HI  = DUR_W'(win_hi(NOM_REP_SPACE,  TOL_PCT));
    localparam logic [DUR_W-1:0] BIT_LO  = DUR_W'(win_lo(NOM_BIT_MARK,   TOL_PCT));
    localparam logic [DUR_W-1:0] BIT_HI  = DUR_W'(win_hi(NOM_BIT_MARK,   TOL_PCT));
    localparam logic [DUR_W-1:0] ONE_LO  = DUR_W'(win_lo(NOM_ONE_SPACE,  TOL_PCT));
    localparam logic [DUR_W-1:0] ONE_HI  = DUR_W'(win_hi(NOM_ONE_SPACE,  TOL_PCT));

    logic             tick, level, fall, rise, sat;
    logic [DUR_W-1:0] dur;

    irin_pulse_timer #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .ir   (ir),
        .tick (tick),
        .level(level),
        .fall (fall),
        .rise (rise),
        .dur  (dur),
        .sat  (sat)
    );

    state_t            state, state_nx;
    logic [31:0]       shift_q, shift_nx;
    logic [4:0]        bit_cnt, bit_cnt_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic              valid_nx, rpt_nx, error_nx;
    logic              in_lead, in_lsp, in_rsp, in_bit, in_one, inv_ok;

    assign in_lead = (dur >= LEAD_LO) && (dur <= LEAD_HI);
    assign in_lsp  = (dur >= LSP_LO)  && (dur <= LSP_HI);
    assign in_rsp  = (dur >= RSP_LO)  && (dur <= RSP_HI);
    assign in_bit  = (dur >= BIT_LO)  && (dur <= BIT_HI);
    assign in_one  = (dur >= ONE_LO)  && (dur <= ONE_HI);
    // byte3 must be the bitwise inverse of byte2 (the command byte).
    assign inv_ok  = (CHECK_INV == 0) || (shift_q[31:24] == ~shift_q[23:16]);

    always_comb begin
        state_nx   = state;
        shift_nx   = shift_q;
        bit_cnt_nx = bit_cnt;
        valid_nx   = 1'b0;
        rpt_nx     = 1'b0;
        error_nx   = 1'b0;
        case (state)
            // The strobe cycle already shows the settled low level.
            ST_IDLE: if (fall && !level) state_nx = ST_LEAD_MARK;
            ST_LEAD_MARK: if (rise) begin
                if (in_lead) state_nx = ST_LEAD_SPACE;
                else begin state_nx = ST_IDLE; error_nx = 1'b1; end
            end
            ST_LEAD_SPACE: if (fall) begin
                if (in_lsp) begin
                    state_nx   = ST_BIT_MARK;
                    bit_cnt_nx = '0;
                end else if (in_rsp) begin
                    state_nx = ST_REP_STOP;
                end else begin
                    state_nx = ST_IDLE;
                    error_nx = 1'b1;
                end
            end
            ST_BIT_MARK: if (rise) begin
                if (in_bit) state_nx = ST_BIT_SPACE;
                else begin state_nx = ST_IDLE; error_nx = 1'b1; end
            end
            // Space ends on the falling edge that starts the next mark.
            ST_BIT_SPACE: if (fall) begin
                if (in_bit || in_one) begin
                    shift_nx   = {in_one, shift_q[31:1]};
                    bit_cnt_nx = bit_cnt + 5'd1;
                    state_nx   = (bit_cnt == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
                end else begin
                    state_nx = ST_IDLE;
                    error_nx = 1'b1;
                end
            end
            ST_STOP_MARK: if (rise) begin
                state_nx = ST_IDLE;
                if (in_bit && inv_ok) valid_nx = 1'b1;
                else                  error_nx = 1'b1;
            end
            ST_REP_STOP: if (rise) begin
                state_nx = ST_IDLE;
                if (!in_bit)      error_nx = 1'b1;
                else if (pressed) rpt_nx   = 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
        // A stuck line mid-frame overrides whatever the edge logic decided.
        if (state != ST_IDLE && sat) begin
            state_nx = ST_IDLE;
            valid_nx = 1'b0;
            rpt_nx   = 1'b0;
            error_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shift_q <= '0;
            bit_cnt <= '0;
            valid   <= 1'b0;
            rpt     <= 1'b0;
            error   <= 1'b0;
            code    <= '0;
            address <= '0;
        end else begin
            state   <= state_nx;
            shift_q <= shift_nx;
            bit_cnt <= bit_cnt_nx;
            valid   <= valid_nx;
            rpt     <= rpt_nx;
            error   <= error_nx;
            if (valid_nx) begin
                code    <= shift_q[23:16];
                address <= shift_q[15:0];
            end
        end
    end

    // Hold timer: a new frame or repeat wins over expiry in the same tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pressed  <= 1'b0;
            hold_cnt <= '0;
        end else if (valid_nx || rpt_nx) begin
            pressed  <= 1'b1;
            hold_cnt <= HOLD_W'(HOLD_US);
        end else if (tick && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            if (hold_cnt == HOLD_W'(1)) pressed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_irin_nec.sv
`timescale 1ns/1ps
module tb_irin_nec;
    import irin_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic ir;
    always #125 clk = ~clk;   // 4 MHz: one microsecond = 4 clocks

    // dut1 checks the inverted command byte, dut0 does not; both share ir.
    logic [7:0]  code1, code0;
    logic [15:0] addr1, addr0;
    logic        v1, r1, e1, p1, v0, r0, e0, p0;

    irin_nec #(.CLK_FREQ_HZ(4000000), .TOL_PCT(25), .CHECK_INV(1), .HOLD_US(110000)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .code(code1), .address(addr1),
        .valid(v1), .rpt(r1), .error(e1), .pressed(p1)
    );

    irin_nec #(.CLK_FREQ_HZ(4000000), .TOL_PCT(25), .CHECK_INV(0), .HOLD_US(110000)) dut_ni (
        .clk(clk), .rst_n(rst_n), .ir(ir), .code(code0), .address(addr0),
        .valid(v0), .rpt(r0), .error(e0), .pressed(p0)
    );

    // ---------------- pulse monitors ----------------
    int    nv1 = 0, nr1 = 0, ne1 = 0, nv0 = 0, ne0 = 0, nov = 0;
    logic  p1_prev = 1'b0;
    longint t_rep = 0, t_drop = 0;

    always @(negedge clk) begin
        if (v1) nv1 <= nv1 + 1;
        if (r1) nr1 <= nr1 + 1;
        if (e1) ne1 <= ne1 + 1;
        if (v0) nv0 <= nv0 + 1;
        if (e0) ne0 <= ne0 + 1;
        if ((int'(v1) + int'(r1) + int'(e1)) > 1) nov <= nov + 1;
        if (r1) t_rep <= $time;
        if (p1_prev && !p1) t_drop <= $time;
        p1_prev <= p1;
    end

    // ---------------- scoreboard ----------------
    int nvec = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic hold_level(input logic lvl, input int us);
        ir = lvl;
        #(us * 1000);
    endtask

    // Leader, nbits data bits (LSB first), optional stop mark; every width
    // scaled by pct/100. Ends with the line high.
    task automatic send_burst(input logic [31:0] word, input int nbits,
                              input bit stop, input int pct);
        hold_level(1'b0, 9000 * pct / 100);
        hold_level(1'b1, 4500 * pct / 100);
        for (int i = 0; i < nbits; i++) begin
            hold_level(1'b0, 560 * pct / 100);
            hold_level(1'b1, (word[i] ? 1690 : 560) * pct / 100);
        end
        if (stop) begin
            hold_level(1'b0, 560 * pct / 100);
            hold_level(1'b1, 1000);
        end
    endtask

    task automatic send_repeat();
        hold_level(1'b0, 9000);
        hold_level(1'b1, 2250);
        hold_level(1'b0, 560);
        hold_level(1'b1, 1000);
    endtask

    // ---------------- directed sequence ----------------
    longint diff;

    initial begin
        ir    = 1'b1;
        rst_n = 1'b0;
        #5000;
        check("rst_code",    32'(code1), 32'h0);
        check("rst_addr",    32'(addr1), 32'h0);
        check("rst_pressed", 32'(p1),    32'h0);
        check("rst_valid",   32'(v1),    32'h0);
        check("rst_state",   32'(dut.state), 32'(ST_IDLE));
        rst_n = 1'b1;
        #100000;

        // repeat with no preceding frame: silent
        send_repeat();
        check("orphan_rpt",   nr1, 0);
        check("orphan_valid", nv1, 0);
        check("orphan_err",   ne1, 0);

        // nominal frame: byte0=00 byte1=FF byte2=45 byte3=BA
        send_burst(32'hBA45FF00, 32, 1'b1, 100);
        check("f1_valid",   nv1, 1);
        check("f1_code",    32'(code1), 32'h45);
        check("f1_addr",    32'(addr1), 32'hFF00);
        check("f1_pressed", 32'(p1), 32'h1);
        check("f1_err",     ne1, 0);
        check("f1_ni_valid", nv0, 1);

        // repeat 40 ms after the frame, then let the hold time expire
        #39000000;
        send_repeat();
        check("rep_pulse",   nr1, 1);
        check("rep_pressed", 32'(p1), 32'h1);
        check("rep_valid",   nv1, 1);
        #112000000;
        check("hold_release", 32'(p1), 32'h0);
        diff = t_drop - t_rep;
        check("hold_time", 32'((diff >= 64'd109999000) && (diff <= 64'd110001000)), 32'h1);

        // reset after bit 12 of a frame, then a clean frame, then a glitch
        send_burst(32'h5AA51234, 13, 1'b0, 100);
        rst_n = 1'b0;
        #5000;
        rst_n = 1'b1;
        #200000;
        check("mrst_err",     ne1, 0);
        check("mrst_valid",   nv1, 1);
        check("mrst_rpt",     nr1, 1);
        check("mrst_code",    32'(code1), 32'h0);
        check("mrst_addr",    32'(addr1), 32'h0);
        check("mrst_pressed", 32'(p1), 32'h0);
        send_burst(32'h5AA51234, 32, 1'b1, 100);
        check("f2_valid", nv1, 2);
        check("f2_code",  32'(code1), 32'hA5);
        check("f2_addr",  32'(addr1), 32'h1234);
        check("f2_err",   ne1, 0);
        hold_level(1'b0, 2);
        hold_level(1'b1, 1000);
        check("glitch_err",   ne1, 0);
        check("glitch_state", 32'(dut.state), 32'(ST_IDLE));
        check("glitch_valid", nv1, 2);

        // byte3 = BB: rejected with inverse check, accepted without
        send_burst(32'hBB45FF00, 32, 1'b1, 100);
        check("inv_err",      ne1, 1);
        check("inv_valid",    nv1, 2);
        check("inv_code",     32'(code1), 32'hA5);
        check("inv_addr",     32'(addr1), 32'h1234);
        check("noinv_valid",  nv0, 3);
        check("noinv_code",   32'(code0), 32'h45);
        check("noinv_addr",   32'(addr0), 32'hFF00);
        check("noinv_err",    ne0, 0);

        // all widths +20%: inside the 25% window
        send_burst(32'hBA45FF00, 32, 1'b1, 120);
        check("s120_valid", nv1, 3);
        check("s120_code",  32'(code1), 32'h45);
        check("s120_err",   ne1, 1);

        // +30%: leader mark already out of window
        send_burst(32'hBA45FF00, 0, 1'b0, 130);
        #1000000;
        check("s130_err",   ne1, 2);
        check("s130_valid", nv1, 3);
        check("s130_state", 32'(dut.state), 32'(ST_IDLE));
        check("s130_code",  32'(code1), 32'h45);

        check("pulse_overlap", nov, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
